// File: rtl/sr_pkg.sv
// Shared definitions for the shift-register word driver: word width, FSM state type
// and the helper that picks the outgoing serial bit.
package sr_pkg;

    localparam int WORD_W = 3;
    localparam logic [1:0] LAST_BIT = 2'(WORD_W - 1);

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Index 0 is the MSB; the LSB leaves first so it ends up in the last stage.
    function automatic logic serial_bit(input word_t w, input logic [1:0] cnt);
        logic b;
        case (cnt)
            2'd0:    b = w[2];
            2'd1:    b = w[1];
            default: b = w[0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sr_word_driver_if.sv
// Upstream word handshake plus the shift-register drive bus of sr_word_driver.
interface sr_word_driver_if;
    import sr_pkg::*;

    logic       in_valid;
    logic       in_ready;
    word_t      in_word;
    logic       in_mode;
    logic       data;
    logic       load;
    word_t      d;
    logic       done;
    logic [7:0] sent_count;

    modport master (
        output in_valid, in_word, in_mode,
        input  in_ready, data, load, d, done, sent_count
    );

    modport slave (
        input  in_valid, in_word, in_mode,
        output in_ready, data, load, d, done, sent_count
    );

endinterface

// File: rtl/three_bit_sr.sv
// Downstream 3-bit shift register: parallel load, otherwise shifts data into stage 0.
module three_bit_sr
    import sr_pkg::*;
(
    input  logic  clk,
    input  logic  data,
    input  logic  load,
    input  word_t d,
    output word_t q
);

    always_ff @(posedge clk) begin
        if (load) begin
            q <= d;
        end else begin
            q <= {data, q[0:WORD_W-2]};
        end
    end

endmodule

// File: rtl/sr_word_driver.sv
// Delivers 3-bit words to a shift register either by parallel load or by three
// serial shifts, pulsing done when the register holds the word.
module sr_word_driver
    import sr_pkg::*;
#(
    parameter logic IDLE_BIT = 1'b0
)
(
    input  logic            clk,
    input  logic            reset,
    sr_word_driver_if.slave bus
);

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    word_t      word_reg, word_next;
    logic [7:0] count_reg, count_next;

    logic ready;
    logic accept;
    logic load_w;

    assign ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE);
    assign accept = bus.in_valid && ready;
    assign load_w = (state_reg == ST_LOAD);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        word_next  = word_reg;
        count_next = count_reg;

        if (accept) begin
            word_next = bus.in_word;
        end

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (state_reg == ST_DONE) begin
                    count_next = count_reg + 8'd1;
                end
                // DONE accepts directly so back-to-back words lose no cycle
                if (accept) begin
                    state_next = bus.in_mode ? ST_SHIFT : ST_LOAD;
                    cnt_next   = 2'd0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next = ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_reg == LAST_BIT) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            word_reg  <= '0;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            word_reg  <= word_next;
            count_reg <= count_next;
        end
    end

    // Outputs depend on registered state only, never on in_valid.
    assign bus.in_ready   = ready;
    assign bus.load       = load_w;
    assign bus.done       = (state_reg == ST_DONE);
    assign bus.sent_count = count_reg;
    assign bus.data       = (state_reg == ST_SHIFT) ? serial_bit(word_reg, cnt_reg) : IDLE_BIT;

    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_d
            assign bus.d[gi] = load_w & word_reg[gi];
        end
    endgenerate

endmodule
